multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore/Mealy control FSM that sequences the multi-cycle RV32I datapath: shared memory port, IR/PC writes, register-file writeback and ALU operand muxes.
- Drives the 2-bit alu_op consumed by the alu_control decoder: 00 = add, 01 = subtract/compare, 10 = decode from funct3/funct7.
- Supported opcodes: R-type 0110011, LW 0000011, SW 0100011, BEQ 1100011. Other opcodes raise illegal_op.
- Memory accesses use a ready handshake with a timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 16, maximum wait cycles for mem_ready in any memory state before abort (must be ≥ 1).
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  IR[6:0], valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by zero (BEQ)
- pc_source  output  1  0 = ALU result, 1 = ALUOut register
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load enable
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register-file write enable
- alu_src_a  output  1  0 = PC, 1 = A register
- alu_src_b  output  2  00 = B register, 01 = constant 4, 10 = immediate
- alu_op  output  2  to alu_control
- instr_retired  output  1  one-cycle pulse on instruction completion
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- mem_timeout  output  1  one-cycle pulse on handshake abort
- state_dbg  output  4  current state encoding

Behaviour:
- State encoding:
  - RESET = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_RD = 4, MEM_WB = 5, MEM_WR = 6, EXEC = 7, ALU_WB = 8, BRANCH = 9.
  - Codes 10–15 are unreachable and go to FETCH.
- rst_n low: state = RESET and wait counter = 0 immediately.
  - All enables and pulses are 0; alu_op = 00, alu_src_a = 0, alu_src_b = 00, pc_source = 0, i_or_d = 0.
  - Reset asserted mid-access drops mem_read/mem_write in the same cycle (asynchronous).
- RESET: all outputs default; next state is FETCH unconditionally.
- FETCH:
  - Asserts mem_read, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00.
  - ir_write and pc_write are asserted only in the cycle where mem_ready = 1 (Mealy); the state then goes to DECODE.
- DECODE:
  - alu_src_a = 0, alu_src_b = 10, alu_op = 00 (branch target into ALUOut).
  - Next state by opcode: LW/SW → MEM_ADDR, R-type → EXEC, BEQ → BRANCH.
  - Any other opcode: illegal_op = 1 this cycle, next state FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD:
  - mem_read = 1, i_or_d = 1.
  - On mem_ready → MEM_WB. The MDR is loaded by the datapath every cycle, so no enable is needed.
- MEM_WB: reg_write = 1, mem_to_reg = 1, instr_retired = 1; next state FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1. On mem_ready: instr_retired = 1, next state FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10; next state ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0, instr_retired = 1; next state FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 1, instr_retired = 1.
  - Next state FETCH whether or not the branch is taken.
- Wait counter (memory handshake):
  - Clears on every state change.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready = 0.
  - If it equals TIMEOUT_CYCLES − 1 and mem_ready is still 0: mem_timeout = 1 this cycle and next state is FETCH.
  - On this abort path ir_write, pc_write, reg_write and instr_retired stay 0.
  - mem_ready = 1 in that same cycle wins: the access completes normally and there is no timeout.
  - Zero-wait memory (mem_ready held high) gives FETCH in 1 cycle.
- Cycle counts with zero-wait memory: LW 5, SW 4, R-type 4, BEQ 3, illegal 2 (FETCH, DECODE).
- Outputs not listed for a state are 0/default.
- mem_read and mem_write are never both 1. reg_write and any memory request are never both 1.

Test Plan:
- Reset release with mem_ready = 1, opcode = 0110011:
  - state_dbg sequence is 0, 1, 2, 7, 8, 1.
  - alu_op = 10 in EXEC; reg_write = 1 in ALU_WB; instr_retired pulses once.
- LW (0000011) with mem_ready low 3 cycles in MEM_RD:
  - MEM_RD lasts 4 cycles, then MEM_WB with mem_to_reg = 1, reg_write = 1.
  - Total 8 cycles from FETCH.
- BEQ (1100011):
  - BRANCH drives alu_op = 01, pc_write_cond = 1, pc_source = 1.
  - pc_write = 0 in BRANCH; the next state is FETCH for both zero = 0 and zero = 1.
- Opcode 0010011 in DECODE: illegal_op pulses exactly one cycle, next state FETCH, reg_write never asserted.
- mem_ready held 0 in FETCH, TIMEOUT_CYCLES = 16:
  - mem_timeout pulses on the 16th FETCH cycle, ir_write stays 0, and FETCH re-enters with the counter cleared.
  - With mem_ready = 1 on the 16th cycle instead: normal fetch, no timeout.
- rst_n pulled low mid-MEM_WR while mem_write = 1:
  - mem_write drops asynchronously and state_dbg = 0.
  - After release the sequence is 0 then 1.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM sequencing the multi-cycle RV32I datapath with a memory ready/timeout handshake
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_retired,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
);
  localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
                         S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_EXEC = 4'd7,
                         S_ALU_WB = 4'd8, S_BRANCH = 4'd9;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;
  logic [3:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wait_st, tmo;
  logic unused_zero;
  assign unused_zero = zero;
  assign state_dbg = state_q;
  assign wait_st = state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR;
  assign tmo = wait_st && !mem_ready && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign mem_timeout = tmo;
  always_comb begin
    state_d = state_q;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    pc_source = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    instr_retired = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        illegal_op = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_R || opcode == OP_BEQ);
        state_d = (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                  opcode == OP_R ? S_EXEC : opcode == OP_BEQ ? S_BRANCH : S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d = opcode == OP_SW ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
        state_d = mem_ready ? S_MEM_WB : tmo ? S_FETCH : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        instr_retired = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d = 1'b1;
        instr_retired = mem_ready;
        state_d = (mem_ready || tmo) ? S_FETCH : S_MEM_WR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = 2'b10;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        instr_retired = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 2'b01;
        pc_write_cond = 1'b1;
        pc_source = 1'b1;
        instr_retired = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end
  // a timeout restarts FETCH in place, so it must clear the counter like a state change
  assign cnt_d = (state_d != state_q || tmo) ? '0 : (wait_st && !mem_ready) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
